// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_DATA_BITS    = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with synchronous clear; flags the half-bit and full-bit positions.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign half_tick = en && (cnt == HALF);
  assign full_tick = en && (cnt == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= full_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-bit qualification, mid-bit sampling,
// optional parity check and stop-bit check, one-cycle valid strobe per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_meta, rx_s;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l, par_odd_l, par_err_int;
  logic                 cnt_clr, half_tick, full_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // The counter free-runs from the first low cycle in IDLE, so the count equals
  // the cycle offset from the start edge; it is re-zeroed once the start bit is judged.
  always_comb begin
    cnt_clr = 1'b0;
    case (state)
      ST_IDLE:      cnt_clr = rx_s;
      ST_START:     cnt_clr = half_tick;
      ST_WAIT_IDLE: cnt_clr = 1'b1;
      default:      cnt_clr = 1'b0;
    endcase
  end

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (1'b1),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shreg       <= '0;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      par_err_int <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          par_en_l  <= parity_en;
          par_odd_l <= parity_odd;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (half_tick) begin
            if (!rx_s) begin
              state       <= ST_DATA;
              idx         <= '0;
              par_err_int <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == LAST_IDX) state <= par_en_l ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            par_err_int <= rx_s != (^shreg ^ par_odd_l);
            state       <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            rx_data    <= shreg;
            parity_err <= par_en_l & par_err_int;
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
            state      <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames scored
// against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned N = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned at;
  } strobe_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  strobe_t     got[$];
  logic        busy_q[$];
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_valid) busy_q.push_back(busy);
    prev_valid <= rx_valid;
    if (rx_valid) got.push_back('{rx_data, parity_err, frame_err, cyc});
  end

  // Reference model: what a frame's fields imply for the host-side outputs.
  function automatic strobe_t model(input logic [7:0] d, input logic pen, input logic podd,
                                    input logic pbit, input logic stop);
    strobe_t s;
    logic    want_pbit;
    want_pbit = logic'($countones(d) % 2) ^ podd;
    s.data = d;
    s.perr = pen && (pbit != want_pbit);
    s.ferr = !stop;
    s.at   = 0;
    return s;
  endfunction

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int unsigned nbits);
    rx_in = 1'b1;
    repeat (nbits * N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stop);
    parity_en  = pen;
    parity_odd = podd;
    drive_bit(1'b0);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_in = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b want=0", parity_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_clean;
    got.delete(); busy_q.delete();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL clean_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0].data !== 8'hA5) begin bad++; $display("FAIL clean_data got=%h want=a5", got[0].data); end
      total++; if (got[0].perr !== 1'b0) begin bad++; $display("FAIL clean_perr got=%b want=0", got[0].perr); end
      total++; if (got[0].ferr !== 1'b0) begin bad++; $display("FAIL clean_ferr got=%b want=0", got[0].ferr); end
    end
    total++;
    if (busy_q.size() < 1 || busy_q[0] !== 1'b0) begin
      bad++; $display("FAIL clean_busy_after got=%b want=0", busy_q.size() > 0 ? busy_q[0] : 1'bx);
    end
  endtask

  task automatic test_parity;
    logic [7:0] want_d[3]  = '{8'h37, 8'h37, 8'h00};
    logic       want_pe[3] = '{1'b0, 1'b1, 1'b0};
    got.delete();
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b1); idle_bits(1);
    send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b1); idle_bits(1);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1); idle_bits(2);
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL parity_count got=%0d want=3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got[i].data !== want_d[i]) begin bad++; $display("FAIL parity_data[%0d] got=%h want=%h", i, got[i].data, want_d[i]); end
        total++; if (got[i].perr !== want_pe[i]) begin bad++; $display("FAIL parity_err[%0d] got=%b want=%b", i, got[i].perr, want_pe[i]); end
      end
    end
  endtask

  task automatic test_random;
    strobe_t     exp_q[$];
    logic        last_stop = 1'b1;
    logic [7:0]  d;
    logic        pen, podd, pbit, stop;
    int unsigned gap;
    got.delete();
    for (int f = 0; f < 24; f++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(7) != 0);
      gap  = $urandom_range(2);
      if (!last_stop && gap == 0) gap = 1;
      if (gap != 0) idle_bits(gap);
      send_frame(d, pen, podd, pbit, stop);
      exp_q.push_back(model(d, pen, podd, pbit, stop));
      last_stop = stop;
    end
    idle_bits(2);
    total++;
    if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count got=%0d want=%0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got[i].data !== exp_q[i].data || got[i].perr !== exp_q[i].perr || got[i].ferr !== exp_q[i].ferr) begin
          bad++;
          $display("FAIL random_frame[%0d] got=%h/p%b/f%b want=%h/p%b/f%b", i, got[i].data, got[i].perr,
                   got[i].ferr, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int busy_cycles = 0;
    got.delete();
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (3 * N) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    total++; if (got.size() != 0) begin bad++; $display("FAIL glitch_strobe got=%0d want=0", got.size()); end
    total++; if (busy_cycles < 1 || busy_cycles > 8) begin bad++; $display("FAIL glitch_busy_len got=%0d want=1..8", busy_cycles); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
  endtask

  task automatic test_break;
    got.delete();
    parity_en = 1'b0;
    rx_in = 1'b0;
    repeat (20 * N) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy); end
    idle_bits(2);
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL break_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0].data !== 8'h00) begin bad++; $display("FAIL break_data got=%h want=00", got[0].data); end
      total++; if (got[0].ferr !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", got[0].ferr); end
    end
    got.delete();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL after_break_count got=%0d want=1", got.size()); end
    else begin
      total++;
      if (got[0].data !== 8'h5A || got[0].ferr !== 1'b0 || got[0].perr !== 1'b0) begin
        bad++; $display("FAIL after_break_frame got=%h/p%b/f%b want=5a/p0/f0", got[0].data, got[0].perr, got[0].ferr);
      end
    end
  endtask

  task automatic test_reset_mid_back_to_back;
    got.delete();
    parity_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_in = 1'b1;
    repeat (N / 2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%h/v%b/p%b/f%b/b%b want=00/v0/p0/f0/b0",
                      rx_data, rx_valid, parity_err, frame_err, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(1);
    total++; if (got.size() != 0) begin bad++; $display("FAIL midreset_strobe got=%0d want=0", got.size()); end
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    total++;
    if (got.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got.size()); end
    else begin
      total++; if (got[0].data !== 8'h11) begin bad++; $display("FAIL b2b_data0 got=%h want=11", got[0].data); end
      total++; if (got[1].data !== 8'hEE) begin bad++; $display("FAIL b2b_data1 got=%h want=ee", got[1].data); end
      total++;
      if (got[1].at - got[0].at != 10 * N) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=%0d", got[1].at - got[0].at, 10 * N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_glitch();
    test_random();
    test_break();
    test_reset_mid_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the transmit path's start/data/parity/stop bit multiplexer. It synchronises the asynchronous serial line, detects a start bit, samples each bit at mid-bit using an internal baud counter, and checks optional parity and the stop bit. It presents one byte per frame to the host side with a single-cycle valid strobe and error flags.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 4.
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5–8.
- clk  input  1  system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line; idles high; asynchronous to clk.
- parity_en  input  1  1 = frame carries a parity bit after the data bits.
- parity_odd  input  1  1 = odd parity, 0 = even parity. Sampled with parity_en at start-bit detect.
- rx_data  output  DATA_BITS  received byte; held until the next frame completes.
- rx_valid  output  1  one-cycle strobe: rx_data and the error flags are updated.
- parity_err  output  1  parity mismatch for the last frame; valid with rx_valid.
- frame_err  output  1  stop bit sampled low for the last frame; valid with rx_valid.
- busy  output  1  high from start-bit detect until return to IDLE.

## Operation
- rx_in passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE**
  - rx_s == 0 → START; clear the baud counter.
  - Latch parity_en and parity_odd.
- **START**
  - At count CLKS_PER_BIT/2 − 1 (integer division), sample rx_s.
  - If the sample is 0, the start bit is confirmed → DATA; restart the counter and set the bit index to 0.
  - If the sample is 1, it is a glitch → IDLE with no strobe and no flag change.
- **DATA**
  - Each time the counter reaches CLKS_PER_BIT − 1, sample rx_s into shift-register bit[index] (LSB first) and increment the index.
  - After DATA_BITS samples → PARITY if the parity was latched, else → STOP.
- **PARITY**
  - One sample.
  - Expected bit = XOR of the data bits, XOR parity_odd.
  - Mismatch sets an internal error bit.
- **STOP**
  - One sample. A value of 0 sets the internal frame error.
  - On the sample cycle, the next state is IDLE if the sample is 1, else WAIT_IDLE.
- **WAIT_IDLE** (break or framing error): stay until rx_s == 1, then → IDLE. No new start is detected while in this state.
- **Outputs on stop-bit sample**
  - rx_data, parity_err and frame_err register the new values, and rx_valid pulses.
  - This happens on a frame error too; the host discards the data.
  - parity_err is 0 whenever parity was not enabled.
- busy = (state != IDLE).

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0, state = IDLE.
- Start-edge latency: a falling edge on rx_in is seen by the FSM 2 cycles later through the synchroniser.
- Sample points: relative to the first cycle with rx_s == 0, bit k (start = 0) is sampled at cycle CLKS_PER_BIT/2 − 1 + k·CLKS_PER_BIT.
- rx_valid is high in the cycle after the stop-bit sample, for exactly 1 cycle. Outputs are stable from that edge onward.
- Back-to-back frames: a new start edge arriving in the cycle after return to IDLE is accepted. There are no idle-cycle requirements beyond the stop bit.
- parity_en and parity_odd changing mid-frame have no effect on the current frame.
- Reset mid-frame returns immediately to IDLE with all outputs at reset values. No partial strobe is produced.
- No backpressure: rx_valid is not held, and a missed strobe loses the byte.

## Structure
- **Shared package uart_pkg:**
  - FSM state encoding (3-bit localparams).
  - Default CLKS_PER_BIT and DATA_BITS.
  - Parity-mode constants, shared with the transmitter.
- **Sub-module uart_baud_cnt:**
  - Counter with clear and enable inputs.
  - Outputs: a half-bit tick and a full-bit tick.
  - Reusable by the TX side.
- The synchroniser is inline (2 flops). The FSM, shift register and parity accumulator stay in uart_rx.

## Test plan
- **Clean frame:** CLKS_PER_BIT = 16, no parity, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1). Required: one rx_valid, rx_data = 0xA5, both error flags 0, busy low 1 cycle after the strobe.
- **Even parity good/bad:** send 0x37 with parity bit 1, then the same frame with parity bit 0. Required: parity_err = 0, then parity_err = 1; rx_data = 0x37 both times.
- **Odd parity:** parity_odd = 1, send 0x00 with parity bit 1. Required: parity_err = 0.
- **Glitch rejection:** drive rx_in low for 5 cycles, then high. Required: no rx_valid, state returns to IDLE, busy pulse at most 8 cycles long.
- **Break:** hold rx_in low for 20 bit times. Required: one rx_valid with rx_data = 0x00 and frame_err = 1, no further strobes. A valid 0x5A frame after the line returns high is then received correctly.
- **Reset mid-frame, then back-to-back:**
  - Assert rst_n low during bit 3 of a frame. Required: all outputs 0, no strobe.
  - Then send 0x11 and 0xEE with no idle gap. Required: two strobes, exactly 10·16 cycles apart.
